wb_hex_reply_tx: RTL and testbench
==================================

// Module: wb_hex_reply_tx
// PURPOSE
//  Reply path of the UART-to-Wishbone command bridge. Takes one completed bus read
//  (address, data, error flag) and streams it to the UART transmitter as an ASCII hex
//  line: normal "<ADDR>=<DATA>\r\n", error "!<ADDR>\r\n".
//  Sits between the bridge FSM (read-complete strobe) and UartTop's in_w_data/in_valid/out_BUSY.
// PARAMETERS
//  ADDR_W      8  address width in bits; must be a multiple of 4 (ADDR_W/4 hex digits)
//  DATA_W      8  data width in bits; must be a multiple of 4 (DATA_W/4 hex digits)
//  UPPERCASE   1  1: hex letters 'A'-'F' (0x41..); 0: 'a'-'f' (0x61..)
//  BUSY_GUARD  2  cycles after a tx strobe before a low i_tx_busy counts as "done"
// PORTS
//  i_clk        in   1       system clock (12 MHz)
//  i_reset      in   1       asynchronous reset, active-high
//  i_valid      in   1       reply request; held by source until accepted
//  i_addr       in   ADDR_W  address of the completed read
//  i_data       in   DATA_W  read data
//  i_err        in   1       1 = bus error/timeout; the data field is not sent
//  o_ready      out  1       1 = request accepted this cycle if i_valid=1
//  o_tx_data    out  8       byte to the UART transmitter
//  o_tx_valid   out  1       one-cycle strobe: o_tx_data is valid
//  i_tx_busy    in   1       UART transmitter busy
//  o_active     out  1       1 while a frame is in progress
// BEHAVIOUR
//  Reset (async, i_reset=1): state IDLE; o_ready=1, o_tx_valid=0, o_tx_data=0, o_active=0,
//   char index=0, guard counter=0. A frame in progress is dropped at once; no partial byte strobed.
//  Accept: i_valid & o_ready -> latch addr/data/err into shadow regs. o_ready=0 and
//   o_active=1 from the next cycle. o_ready=(state==IDLE) is registered.
//  Frame: normal = ADDR_W/4 addr digits MSN first, '=' (0x3D), DATA_W/4 data digits
//   MSN first, CR (0x0D), LF (0x0A). err=1 -> '!' (0x21), addr digits, CR, LF.
//  Digit: nibble<10 -> 0x30+n; else (UPPERCASE?0x41:0x61)+n-10.
//  FSM: IDLE -> WAIT_FREE -> SEND -> GUARD -> WAIT_FREE ... -> IDLE
//   WAIT_FREE: stay while i_tx_busy=1; on 0 go to SEND.
//   SEND (1 cycle): o_tx_valid=1, o_tx_data=current char; load guard=BUSY_GUARD.
//   GUARD: decrement each cycle; at 0 and i_tx_busy=0 -> next char (WAIT_FREE),
//    or IDLE after LF. i_tx_busy=1 at any time in GUARD ends the guard count early,
//    and the FSM waits for busy=0.
//  Latency: accept -> first strobe = 2 cycles when the tx is idle. Strobes are never closer
//   together than BUSY_GUARD+2 cycles.
//  i_tx_busy=1 at accept: the first byte is held until busy drops; no byte is lost.
//  i_valid while active: ignored (o_ready=0). A new frame can be accepted on the cycle
//   the FSM returns to IDLE. Back-to-back frames carry no gap byte.
//  Inputs change after accept: no effect; only the shadow regs are used.
//  Char index width = clog2(ADDR_W/4+DATA_W/4+4). The index resets to 0 on every accept.
// STRUCTURE
//  wb_uart_pkg holds:
//   - ASCII constants: CH_EQ, CH_BANG, CH_CR, CH_LF
//   - function nibble_to_ascii(nib, upper)
//   - state enum typedef reply_state_t
//  No sub-module. The char mux and FSM are inline, and use the package function.
// TESTING
//  1 Defaults, addr=0x3A, data=0x5C, err=0, tx idle -> strobes 33 41 3D 35 43 0D 0A.
//    First strobe 2 cycles after accept; o_active falls after the LF.
//  2 err=1, addr=0x0F -> strobes 21 30 46 0D 0A; no '=' and no data digits.
//  3 UPPERCASE=0, addr=0xAB, data=0xFE -> 61 62 3D 66 65 0D 0A.
//  4 Hold i_tx_busy=1 for 50 cycles at accept -> zero strobes during hold. First byte
//    0x33 comes 1 cycle after busy falls. Bench UART model asserts busy 1 cycle after each
//    strobe -> exactly 7 bytes, none duplicated.
//  5 Hold i_valid during a frame with new addr/data -> o_ready=0 throughout; the frame
//    matches the first request. The second request is accepted at IDLE and sent in full.
//  6 Assert i_reset mid-frame (after byte 3) -> o_tx_valid=0 and o_ready=1 asynchronously.
//    After release, a fresh request yields a complete, correct frame.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the UART-to-Wishbone bridge reply path:
// ASCII framing constants, hex digit encoding and the reply FSM state type.
package wb_uart_pkg;

   localparam logic [7:0] CH_EQ   = 8'h3D;
   localparam logic [7:0] CH_BANG = 8'h21;
   localparam logic [7:0] CH_CR   = 8'h0D;
   localparam logic [7:0] CH_LF   = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_FREE,
      ST_SEND,
      ST_GUARD
   } reply_state_t;

   // Upper selects 'A'-'F' versus 'a'-'f' for nibbles 10..15.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic upper);
      logic [7:0] base;
      base = upper ? 8'h41 : 8'h61;
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return base + {4'h0, nib} - 8'd10;
   endfunction

endpackage

// File: rtl/wb_hex_reply_tx.sv
// Streams one completed bus read to the UART transmitter as an ASCII hex line:
// "<ADDR>=<DATA>\r\n" on success, "!<ADDR>\r\n" on bus error.
module wb_hex_reply_tx
   import wb_uart_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int UPPERCASE  = 1,
   parameter int BUSY_GUARD = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_err,
   output logic              o_ready,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_busy,
   output logic              o_active
);

   localparam int   ADDR_DIG = ADDR_W / 4;
   localparam int   DATA_DIG = DATA_W / 4;
   localparam int   IDX_W    = $clog2(ADDR_DIG + DATA_DIG + 4);
   localparam int   GUARD_W  = (BUSY_GUARD > 0) ? $clog2(BUSY_GUARD + 1) : 1;
   localparam int   LAST_N   = ADDR_DIG + DATA_DIG + 2;
   localparam int   LAST_E   = ADDR_DIG + 2;
   localparam logic UPPER    = (UPPERCASE != 0);

   reply_state_t      r_state;
   reply_state_t      w_next_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_err;
   logic [IDX_W-1:0]  r_idx;
   logic [GUARD_W-1:0] r_guard;
   logic              r_ready;

   logic              w_accept;
   logic              w_last;
   logic              w_guard_done;
   logic [7:0]        w_char;

   assign w_accept     = i_valid & r_ready;
   assign w_last       = r_err ? (int'(r_idx) == LAST_E) : (int'(r_idx) == LAST_N);
   assign w_guard_done = (r_guard == '0) && !i_tx_busy;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: combinational blocks assign a default first so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:      if (w_accept)   w_next_state = ST_WAIT_FREE;
         ST_WAIT_FREE: if (!i_tx_busy) w_next_state = ST_SEND;
         ST_SEND:                      w_next_state = ST_GUARD;
         ST_GUARD:     if (w_guard_done) w_next_state = w_last ? ST_IDLE : ST_WAIT_FREE;
         default:                      w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: every register here is a flop with a defined reset value; an abort
   // mid-frame leaves nothing stale that could leak into the next frame.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_addr  <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
         r_idx   <= '0;
         r_guard <= '0;
         r_ready <= 1'b1;
      end else begin
         r_ready <= (w_next_state == ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr <= i_addr;
                  r_data <= i_data;
                  r_err  <= i_err;
                  r_idx  <= '0;
               end
            end
            ST_SEND: r_guard <= GUARD_W'(BUSY_GUARD);
            ST_GUARD: begin
               // A busy transmitter cuts the guard short; we then only wait for it to go idle.
               if (w_guard_done) begin
                  r_idx <= r_idx + IDX_W'(1);
               end else if (i_tx_busy) begin
                  r_guard <= '0;
               end else begin
                  r_guard <= r_guard - GUARD_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Character at the current index; digits are taken MSN first from the shadow regs.
   always_comb begin
      int idx;
      int pos;
      idx    = int'(r_idx);
      pos    = 0;
      w_char = 8'h00;
      if (r_err) begin
         if (idx == 0) begin
            w_char = CH_BANG;
         end else if (idx <= ADDR_DIG) begin
            pos    = ADDR_DIG - idx;
            w_char = nibble_to_ascii(4'(r_addr >> (4 * pos)), UPPER);
         end else if (idx == ADDR_DIG + 1) begin
            w_char = CH_CR;
         end else begin
            w_char = CH_LF;
         end
      end else begin
         if (idx < ADDR_DIG) begin
            pos    = ADDR_DIG - 1 - idx;
            w_char = nibble_to_ascii(4'(r_addr >> (4 * pos)), UPPER);
         end else if (idx == ADDR_DIG) begin
            w_char = CH_EQ;
         end else if (idx <= ADDR_DIG + DATA_DIG) begin
            pos    = ADDR_DIG + DATA_DIG - idx;
            w_char = nibble_to_ascii(4'(r_data >> (4 * pos)), UPPER);
         end else if (idx == ADDR_DIG + DATA_DIG + 1) begin
            w_char = CH_CR;
         end else begin
            w_char = CH_LF;
         end
      end
   end

   always_comb begin
      o_tx_valid = (r_state == ST_SEND);
      o_tx_data  = (r_state == ST_SEND) ? w_char : 8'h00;
      o_active   = (r_state != ST_IDLE);
      o_ready    = r_ready;
   end

endmodule

// File: tb/tb_wb_hex_reply_tx.sv
// Directed bench for wb_hex_reply_tx: default instance plus a lowercase-hex instance,
// a simple UART busy model and per-scenario tasks with inline comparisons.
module tb_wb_hex_reply_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_a, err_a, valid_b, err_b;
   logic [7:0] addr_a, data_a, addr_b, data_b;
   logic       ready_a, tx_valid_a, active_a;
   logic       ready_b, tx_valid_b, active_b;
   logic [7:0] tx_data_a, tx_data_b;
   logic       busy_force, busy_model, busy_a, busy_b;
   logic       model_en;
   int         model_cnt;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] qa_byte[$];
   int         qa_cyc[$];
   logic [7:0] qb_byte[$];

   assign busy_a = busy_force | busy_model;

   always #5 clk = ~clk;

   wb_hex_reply_tx u_dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_valid    (valid_a),
      .i_addr     (addr_a),
      .i_data     (data_a),
      .i_err      (err_a),
      .o_ready    (ready_a),
      .o_tx_data  (tx_data_a),
      .o_tx_valid (tx_valid_a),
      .i_tx_busy  (busy_a),
      .o_active   (active_a)
   );

   wb_hex_reply_tx #(.UPPERCASE(0)) u_dut_lc (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_valid    (valid_b),
      .i_addr     (addr_b),
      .i_data     (data_b),
      .i_err      (err_b),
      .o_ready    (ready_b),
      .o_tx_data  (tx_data_b),
      .o_tx_valid (tx_valid_b),
      .i_tx_busy  (busy_b),
      .o_active   (active_b)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_valid_a) begin
         qa_byte.push_back(tx_data_a);
         qa_cyc.push_back(cyc);
      end
      if (tx_valid_b) qb_byte.push_back(tx_data_b);
   end

   // UART model: busy rises the cycle after a strobe and stays high for 12 cycles.
   always @(posedge clk) begin
      if (!model_en) begin
         busy_model <= 1'b0;
         model_cnt  <= 0;
      end else if (tx_valid_a) begin
         busy_model <= 1'b1;
         model_cnt  <= 12;
      end else if (model_cnt > 0) begin
         model_cnt <= model_cnt - 1;
         if (model_cnt == 1) busy_model <= 1'b0;
      end
   end

   task automatic send_req(input int sel, input logic [7:0] a, input logic [7:0] d,
                           input logic e, input bit keep, output int acc_cyc, output bit ok);
      ok = 1'b0;
      acc_cyc = 0;
      @(negedge clk);
      if (sel == 0) begin
         valid_a = 1'b1; addr_a = a; data_a = d; err_a = e;
      end else begin
         valid_b = 1'b1; addr_b = a; data_b = d; err_b = e;
      end
      for (int i = 0; i < 400; i++) begin
         if ((sel == 0) ? ready_a : ready_b) begin
            ok = 1'b1;
            acc_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      if (!keep) begin
         if (sel == 0) valid_a = 1'b0;
         else          valid_b = 1'b0;
      end
   endtask

   task automatic wait_idle(input int sel, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!((sel == 0) ? active_a : active_b)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic clear_queues();
      qa_byte.delete();
      qa_cyc.delete();
      qb_byte.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (ready_a !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b want 1", ready_a); end
      checks++; if (tx_valid_a !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid_a); end
      checks++; if (tx_data_a !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data_a); end
      checks++; if (active_a !== 1'b0)   begin errors++; $display("FAIL reset_active: got %b want 0", active_a); end
      checks++; if (ready_b !== 1'b1)    begin errors++; $display("FAIL reset_ready_lc: got %b want 1", ready_b); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_normal_frame();
      logic [55:0] exp = 56'h33_41_3D_35_43_0D_0A;
      int acc;
      bit ok, ok2;
      int min_gap;
      clear_queues();
      send_req(0, 8'h3A, 8'h5C, 1'b0, 1'b0, acc, ok);
      wait_idle(0, 500, ok2);
      checks++; if (!(ok && ok2)) begin errors++; $display("FAIL normal_timeout: accept=%b idle=%b want 1/1", ok, ok2); end
      checks++; if (qa_byte.size() != 7) begin errors++; $display("FAIL normal_count: got %0d want 7", qa_byte.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (i >= qa_byte.size() || qa_byte[i] !== exp[8*(6-i) +: 8]) begin
            errors++; $display("FAIL normal_byte%0d: got %h want %h", i, (i < qa_byte.size()) ? qa_byte[i] : 8'hxx, exp[8*(6-i) +: 8]);
         end
      end
      checks++;
      if (qa_cyc.size() == 0 || qa_cyc[0] - acc != 2) begin
         errors++; $display("FAIL normal_latency: got %0d want 2", (qa_cyc.size() > 0) ? qa_cyc[0] - acc : -1);
      end
      min_gap = 1000;
      for (int i = 1; i < qa_cyc.size(); i++) if (qa_cyc[i] - qa_cyc[i-1] < min_gap) min_gap = qa_cyc[i] - qa_cyc[i-1];
      checks++; if (min_gap < 4) begin errors++; $display("FAIL normal_spacing: got %0d want >= 4", min_gap); end
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL normal_ready_after: got %b want 1", ready_a); end
   endtask

   task automatic test_error_frame();
      logic [55:0] exp = 56'h00_00_21_30_46_0D_0A;
      int acc;
      bit ok, ok2;
      clear_queues();
      send_req(0, 8'h0F, 8'h99, 1'b1, 1'b0, acc, ok);
      wait_idle(0, 500, ok2);
      checks++; if (!(ok && ok2)) begin errors++; $display("FAIL err_timeout: accept=%b idle=%b want 1/1", ok, ok2); end
      checks++; if (qa_byte.size() != 5) begin errors++; $display("FAIL err_count: got %0d want 5", qa_byte.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= qa_byte.size() || qa_byte[i] !== exp[8*(4-i) +: 8]) begin
            errors++; $display("FAIL err_byte%0d: got %h want %h", i, (i < qa_byte.size()) ? qa_byte[i] : 8'hxx, exp[8*(4-i) +: 8]);
         end
      end
   endtask

   task automatic test_lowercase();
      logic [55:0] exp = 56'h61_62_3D_66_65_0D_0A;
      int acc;
      bit ok, ok2;
      clear_queues();
      send_req(1, 8'hAB, 8'hFE, 1'b0, 1'b0, acc, ok);
      wait_idle(1, 500, ok2);
      checks++; if (!(ok && ok2)) begin errors++; $display("FAIL lc_timeout: accept=%b idle=%b want 1/1", ok, ok2); end
      checks++; if (qb_byte.size() != 7) begin errors++; $display("FAIL lc_count: got %0d want 7", qb_byte.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (i >= qb_byte.size() || qb_byte[i] !== exp[8*(6-i) +: 8]) begin
            errors++; $display("FAIL lc_byte%0d: got %h want %h", i, (i < qb_byte.size()) ? qb_byte[i] : 8'hxx, exp[8*(6-i) +: 8]);
         end
      end
   endtask

   task automatic test_busy_hold();
      logic [55:0] exp = 56'h33_41_3D_35_43_0D_0A;
      int acc, drop_cyc;
      bit ok, ok2;
      clear_queues();
      busy_force = 1'b1;
      send_req(0, 8'h3A, 8'h5C, 1'b0, 1'b0, acc, ok);
      repeat (50) @(negedge clk);
      checks++; if (qa_byte.size() != 0) begin errors++; $display("FAIL busy_hold_strobes: got %0d want 0", qa_byte.size()); end
      checks++; if (active_a !== 1'b1) begin errors++; $display("FAIL busy_hold_active: got %b want 1", active_a); end
      busy_force = 1'b0;
      model_en   = 1'b1;
      drop_cyc   = cyc;
      wait_idle(0, 2000, ok2);
      checks++; if (!(ok && ok2)) begin errors++; $display("FAIL busy_timeout: accept=%b idle=%b want 1/1", ok, ok2); end
      checks++;
      if (qa_cyc.size() == 0 || qa_cyc[0] - drop_cyc != 1) begin
         errors++; $display("FAIL busy_first_delay: got %0d want 1", (qa_cyc.size() > 0) ? qa_cyc[0] - drop_cyc : -1);
      end
      checks++; if (qa_byte.size() != 7) begin errors++; $display("FAIL busy_count: got %0d want 7", qa_byte.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (i >= qa_byte.size() || qa_byte[i] !== exp[8*(6-i) +: 8]) begin
            errors++; $display("FAIL busy_byte%0d: got %h want %h", i, (i < qa_byte.size()) ? qa_byte[i] : 8'hxx, exp[8*(6-i) +: 8]);
         end
      end
      model_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [111:0] exp = 112'h31_32_3D_33_34_0D_0A_35_36_3D_37_38_0D_0A;
      int acc, viol;
      bit ok, ok2, seen_idle;
      clear_queues();
      send_req(0, 8'h12, 8'h34, 1'b0, 1'b1, acc, ok);
      addr_a = 8'h56;
      data_a = 8'h78;
      viol = 0;
      seen_idle = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (!active_a) begin
            seen_idle = 1'b1;
            break;
         end
         if (ready_a) viol++;
         @(negedge clk);
      end
      checks++; if (!(ok && seen_idle)) begin errors++; $display("FAIL b2b_first_timeout: accept=%b idle=%b want 1/1", ok, seen_idle); end
      checks++; if (viol != 0) begin errors++; $display("FAIL b2b_ready_while_active: got %0d cycles want 0", viol); end
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_idle: got %b want 1", ready_a); end
      checks++; if (qa_byte.size() != 7) begin errors++; $display("FAIL b2b_first_count: got %0d want 7", qa_byte.size()); end
      @(negedge clk);
      valid_a = 1'b0;
      wait_idle(0, 500, ok2);
      checks++; if (!ok2) begin errors++; $display("FAIL b2b_second_timeout: idle=%b want 1", ok2); end
      checks++; if (qa_byte.size() != 14) begin errors++; $display("FAIL b2b_total_count: got %0d want 14", qa_byte.size()); end
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (i >= qa_byte.size() || qa_byte[i] !== exp[8*(13-i) +: 8]) begin
            errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, (i < qa_byte.size()) ? qa_byte[i] : 8'hxx, exp[8*(13-i) +: 8]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [55:0] exp = 56'h43_34_3D_30_39_0D_0A;
      int acc;
      bit ok, ok2, hit;
      clear_queues();
      send_req(0, 8'h3A, 8'h5C, 1'b0, 1'b0, acc, ok);
      hit = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #1;
         if (qa_byte.size() == 4 && tx_valid_a) begin
            hit = 1'b1;
            break;
         end
      end
      checks++; if (!(ok && hit)) begin errors++; $display("FAIL rstmid_reach_byte4: accept=%b reached=%b want 1/1", ok, hit); end
      rst = 1'b1;
      #1;
      checks++; if (tx_valid_a !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid: got %b want 0", tx_valid_a); end
      checks++; if (ready_a !== 1'b1)    begin errors++; $display("FAIL rstmid_ready: got %b want 1", ready_a); end
      checks++; if (active_a !== 1'b0)   begin errors++; $display("FAIL rstmid_active: got %b want 0", active_a); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_queues();
      send_req(0, 8'hC4, 8'h09, 1'b0, 1'b0, acc, ok);
      wait_idle(0, 500, ok2);
      checks++; if (!(ok && ok2)) begin errors++; $display("FAIL rstmid_timeout: accept=%b idle=%b want 1/1", ok, ok2); end
      checks++; if (qa_byte.size() != 7) begin errors++; $display("FAIL rstmid_count: got %0d want 7", qa_byte.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (i >= qa_byte.size() || qa_byte[i] !== exp[8*(6-i) +: 8]) begin
            errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, (i < qa_byte.size()) ? qa_byte[i] : 8'hxx, exp[8*(6-i) +: 8]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      valid_a = 1'b0; addr_a = 8'h00; data_a = 8'h00; err_a = 1'b0;
      valid_b = 1'b0; addr_b = 8'h00; data_b = 8'h00; err_b = 1'b0;
      busy_force = 1'b0;
      busy_b = 1'b0;
      model_en = 1'b0;
      test_reset();
      test_normal_frame();
      test_error_frame();
      test_lowercase();
      test_busy_hold();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
